text_tile_renderer: RTL and testbench

Parametrised character-cell text renderer for the text editor's VGA path, the successor to the fixed-label text screen generator. It holds a writable COLS×ROWS character/colour buffer and renders it through the shared font ROM. It supports runtime glyph scaling (×1/×2/×4), a blinking block cursor and a hardware screen-clear sequencer. It sits between the editor control logic (write side) and the VGA sync/pixel mux (read side), producing `text_rgb`/`text_on` aligned to a delayed `video_on`.

---
 rtl/text_pkg.sv | 28 ++
 rtl/font_rom.sv | 34 +++
 rtl/text_char_ram.sv | 28 ++
 rtl/text_tile_renderer.sv | 239 +++++++++++++++++++++++
 tb/tb_text_tile_renderer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared constants and types for the character-cell text renderer:
// ASCII codes, font geometry, glyph scale encodings and the clear FSM states.
package text_pkg;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam int         FONT_W      = 8;
    localparam int         FONT_H      = 16;

    localparam logic [1:0] SIZE_X1 = 2'b00;
    localparam logic [1:0] SIZE_X2 = 2'b01;
    localparam logic [1:0] SIZE_X4 = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

    // Returns log2 of the glyph magnification; the unused 2'b11 code renders at x1.
    function automatic logic [2:0] scale_shift(input logic [1:0] sel);
        case (sel)
            SIZE_X1: return 3'd0;
            SIZE_X2: return 3'd1;
            SIZE_X4: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/font_rom.sv
// Shared 8x16 font ROM, registered output, addressed {char[6:0], glyph_row[3:0]}.
// Bit 7 of each row is the leftmost pixel.
module font_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [7:0] w_row;

    always_comb begin
        w_row = 8'h00;
        if (addr[10:4] == 7'h41) begin
            case (addr[3:0])
                4'h2:    w_row = 8'b0001_0000;
                4'h3:    w_row = 8'b0011_1000;
                4'h4:    w_row = 8'b0110_1100;
                4'h5:    w_row = 8'b1100_0110;
                4'h6:    w_row = 8'b1100_0110;
                4'h7:    w_row = 8'b1111_1110;
                4'h8:    w_row = 8'b1100_0110;
                4'h9:    w_row = 8'b1100_0110;
                4'hA:    w_row = 8'b1100_0110;
                4'hB:    w_row = 8'b1100_0110;
                default: w_row = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        data <= w_row;
    end

endmodule

// File: rtl/text_char_ram.sv
// Simple dual-port character/colour buffer: one write port, one registered
// read port. A read and write to the same address return the old contents.
module text_char_ram #(
    parameter  int DEPTH = 2400,
    parameter  int WIDTH = 10,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_tile_renderer.sv
// Writable COLS x ROWS text buffer rendered through font_rom with x1/x2/x4
// scaling, block cursor and a hardware clear sequencer. Optional blink: TEXT_CURSOR_BLINK_EN.
module text_tile_renderer
    import text_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int COLOR_W      = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               video_on,
    input  logic               frame_tick,
    input  logic [1:0]         size_sel,
    input  logic               wr_en,
    input  logic [6:0]         wr_col,
    input  logic [4:0]         wr_row,
    input  logic [6:0]         wr_char,
    input  logic [COLOR_W-1:0] wr_color,
    output logic               wr_ready,
    input  logic               clear_req,
    input  logic [6:0]         cursor_col,
    input  logic [4:0]         cursor_row,
    input  logic [COLOR_W-1:0] bg_color,
    output logic [COLOR_W-1:0] text_rgb,
    output logic               text_on,
    output logic               video_on_d,
    output clear_state_t       dbg_state
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int GX_W  = $clog2(FONT_W);
    localparam int GY_W  = $clog2(FONT_H);

    typedef struct packed {
        logic [6:0]         ch;
        logic [COLOR_W-1:0] color;
    } cell_t;

    clear_state_t r_state, w_state_nxt;
    logic [AW-1:0] r_clr_addr, w_clr_addr_nxt;

    logic          w_wr_in_range;
    logic [AW-1:0] w_wr_addr;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    cell_t         w_ram_wdata;

    // wr_en/wr_ready: a cell write is taken on any cycle where both are high;
    // a clear_req in that same cycle takes priority and the write is lost.
    assign wr_ready      = (r_state == IDLE);
    assign dbg_state     = r_state;
    assign w_wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign w_wr_addr     = w_wr_in_range ? AW'(32'(wr_row) * COLS + 32'(wr_col)) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt    = CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            CLEAR: begin
                if (r_clr_addr == AW'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + AW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = w_wr_addr;
        w_ram_wdata = '{ch: wr_char, color: wr_color};
        if (r_state == CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_clr_addr;
            w_ram_wdata = '{ch: ASCII_SPACE, color: bg_color};
        end else if (wr_en && !clear_req && w_wr_in_range) begin
            w_ram_we = 1'b1;
        end
    end

    // Pixel-side address decode feeding the buffer's registered read port (S1).
    logic [2:0]      w_shift;
    logic [9:0]      w_cell_col, w_cell_row;
    logic [GX_W-1:0] w_glyph_x;
    logic [GY_W-1:0] w_glyph_y;
    logic            w_in_range, w_cursor_hit;
    logic [AW-1:0]   w_rd_addr;
    cell_t           w_rd_cell;

    assign w_shift      = scale_shift(size_sel);
    assign w_cell_col   = pixel_x >> (w_shift + 3'd3);
    assign w_cell_row   = pixel_y >> (w_shift + 3'd4);
    assign w_glyph_x    = GX_W'(pixel_x >> w_shift);
    assign w_glyph_y    = GY_W'(pixel_y >> w_shift);
    assign w_in_range   = (32'(w_cell_col) < (COLS >> w_shift)) &&
                          (32'(w_cell_row) < (ROWS >> w_shift));
    assign w_rd_addr    = w_in_range ? AW'(32'(w_cell_row) * COLS + 32'(w_cell_col)) : '0;
    assign w_cursor_hit = (w_cell_col == {3'b000, cursor_col}) &&
                          (w_cell_row == {5'b00000, cursor_row});

    text_char_ram #(
        .DEPTH (DEPTH),
        .WIDTH (7 + COLOR_W)
    ) u_char_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_cell)
    );

    logic [GX_W-1:0]    r_s1_glyph_x, r_s2_glyph_x;
    logic [GY_W-1:0]    r_s1_glyph_y;
    logic               r_s1_in_range, r_s2_in_range;
    logic               r_s1_cursor, r_s2_cursor;
    logic               r_s1_vid, r_s2_vid;
    logic [COLOR_W-1:0] r_s2_color;
    logic [7:0]         w_font_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_glyph_x  <= '0;
            r_s1_glyph_y  <= '0;
            r_s1_in_range <= 1'b0;
            r_s1_cursor   <= 1'b0;
            r_s1_vid      <= 1'b0;
            r_s2_glyph_x  <= '0;
            r_s2_in_range <= 1'b0;
            r_s2_cursor   <= 1'b0;
            r_s2_vid      <= 1'b0;
            r_s2_color    <= '0;
        end else begin
            r_s1_glyph_x  <= w_glyph_x;
            r_s1_glyph_y  <= w_glyph_y;
            r_s1_in_range <= w_in_range;
            r_s1_cursor   <= w_cursor_hit;
            r_s1_vid      <= video_on;
            r_s2_glyph_x  <= r_s1_glyph_x;
            r_s2_in_range <= r_s1_in_range;
            r_s2_cursor   <= r_s1_cursor;
            r_s2_vid      <= r_s1_vid;
            r_s2_color    <= w_rd_cell.color;
        end
    end

    font_rom u_font_rom (
        .clk  (clk),
        .addr ({w_rd_cell.ch, r_s1_glyph_y}),
        .data (w_font_data)
    );

    logic w_blink_on;

`ifdef TEXT_CURSOR_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BCW-1:0] r_blink_cnt;
    logic           r_blink_on;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (r_blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BCW'(1);
            end
        end
    end

    assign w_blink_on = r_blink_on;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic w_unused_frame_tick;
    assign w_unused_frame_tick = frame_tick;
    assign w_blink_on          = 1'b1;
`endif

    logic               w_font_bit;
    logic [COLOR_W-1:0] w_pixel;
    logic [COLOR_W-1:0] r_text_rgb;
    logic               r_text_on, r_video_on_d;

    assign w_font_bit = w_font_data[GX_W'(FONT_W - 1) - r_s2_glyph_x];

    always_comb begin
        w_pixel = bg_color;
        if (r_s2_in_range) begin
            if (r_s2_cursor && w_blink_on) begin
                w_pixel = w_font_bit ? bg_color : r_s2_color;
            end else begin
                w_pixel = w_font_bit ? r_s2_color : bg_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_text_rgb   <= '0;
            r_text_on    <= 1'b0;
            r_video_on_d <= 1'b0;
        end else begin
            r_text_rgb   <= w_pixel;
            r_text_on    <= r_s2_in_range;
            r_video_on_d <= r_s2_vid;
        end
    end

    assign text_rgb   = r_text_rgb;
    assign text_on    = r_text_on;
    assign video_on_d = r_video_on_d;

endmodule

// File: tb/tb_text_tile_renderer.sv
// Self-checking bench for text_tile_renderer: scoreboard of expected
// {video_on_d, text_on, text_rgb} words against a behavioural pixel model.
module tb_text_tile_renderer;
    import text_pkg::*;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int COLOR_W = 3;
    localparam int BF      = 2;
    localparam int DEPTH   = COLS * ROWS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic [9:0]         pixel_x, pixel_y;
    logic               video_on, frame_tick;
    logic [1:0]         size_sel;
    logic               wr_en;
    logic [6:0]         wr_col;
    logic [4:0]         wr_row;
    logic [6:0]         wr_char;
    logic [COLOR_W-1:0] wr_color;
    logic               wr_ready;
    logic               clear_req;
    logic [6:0]         cursor_col;
    logic [4:0]         cursor_row;
    logic [COLOR_W-1:0] bg_color;
    logic [COLOR_W-1:0] text_rgb;
    logic               text_on, video_on_d;
    clear_state_t       dbg_state;

    text_tile_renderer #(
        .COLS         (COLS),
        .ROWS         (ROWS),
        .COLOR_W      (COLOR_W),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .size_sel   (size_sel),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_char    (wr_char),
        .wr_color   (wr_color),
        .wr_ready   (wr_ready),
        .clear_req  (clear_req),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .bg_color   (bg_color),
        .text_rgb   (text_rgb),
        .text_on    (text_on),
        .video_on_d (video_on_d),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [4:0]   exp_q[$];
    string        tag_q[$];
    logic [6:0]   m_char  [DEPTH];
    logic [2:0]   m_color [DEPTH];
    logic         m_inv;
    logic [7:0]   glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                   8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model_pix(input int x, input int y, input logic [1:0] sel,
                                             input logic vid);
        int         s, col, row, idx, gy, gx;
        logic       fb;
        logic [2:0] fg, px;
        s   = (sel == 2'b01) ? 1 : (sel == 2'b10) ? 2 : 0;
        col = x >> (3 + s);
        row = y >> (4 + s);
        if (col >= (COLS >> s) || row >= (ROWS >> s)) return {vid, 1'b0, bg_color};
        idx = row * COLS + col;
        gy  = (y >> s) % 16;
        gx  = (x >> s) % 8;
        fg  = m_color[idx];
        fb  = (m_char[idx] == 7'h41) ? glyph_a[gy][7 - gx] : 1'b0;
        if (col == int'(cursor_col) && row == int'(cursor_row) && m_inv)
            px = fb ? bg_color : fg;
        else
            px = fb ? fg : bg_color;
        return {vid, 1'b1, px};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pop_check();
        logic [4:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {27'd0, video_on_d, text_on, text_rgb}, {27'd0, e});
    endtask

    task automatic drive_pix(input string tag, input int x, input int y, input logic [1:0] sel,
                             input logic vid);
        @(posedge clk); #1;
        if (exp_q.size() == 3) pop_check();
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        size_sel = sel;
        video_on = vid;
        exp_q.push_back(model_pix(x, y, sel, vid));
        tag_q.push_back(tag);
    endtask

    task automatic flush();
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            pop_check();
        end
    endtask

    task automatic do_write(input int col, input int row, input logic [6:0] ch,
                            input logic [2:0] color);
        @(posedge clk); #1;
        wr_en    = 1'b1;
        wr_col   = 7'(col);
        wr_row   = 5'(row);
        wr_char  = ch;
        wr_color = color;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (col < COLS && row < ROWS) begin
            m_char[row * COLS + col]  = ch;
            m_color[row * COLS + col] = color;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        reset_n    = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        video_on   = 1'b0;
        frame_tick = 1'b0;
        size_sel   = 2'b00;
        wr_en      = 1'b0;
        wr_col     = '0;
        wr_row     = '0;
        wr_char    = '0;
        wr_color   = '0;
        clear_req  = 1'b0;
        cursor_col = 7'd79;
        cursor_row = 5'd29;
        bg_color   = 3'b111;
        m_inv      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", text_rgb, 0);
        check("rst_on", text_on, 0);
        check("rst_vid", video_on_d, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_state", dbg_state, IDLE);
        reset_n = 1'b1;

        // Clear with a simultaneous write that must be dropped.
        @(posedge clk); #1;
        clear_req = 1'b1;
        wr_en     = 1'b1;
        wr_col    = 7'd1;
        wr_row    = 5'd1;
        wr_char   = 7'h41;
        wr_color  = 3'b001;
        @(posedge clk); #1;
        clear_req = 1'b0;
        wr_en     = 1'b0;
        check("clr_state", dbg_state, CLEAR);
        cnt = 0;
        while (wr_ready == 1'b0 && cnt < 3000) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("clr_len", cnt, 2400);
        for (int i = 0; i < DEPTH; i++) begin
            m_char[i]  = ASCII_SPACE;
            m_color[i] = bg_color;
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                drive_pix("clr_cell", c * 8 + $urandom_range(0, 7), r * 16 + $urandom_range(0, 15),
                          2'b00, 1'b1);
        for (int x = 8; x < 16; x++) drive_pix("clr_drop", x, 23, 2'b00, 1'b1);
        flush();

        // Reset in the middle of a clear.
        @(posedge clk); #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("mid_busy", wr_ready, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_ready", wr_ready, 1);
        check("mid_state", dbg_state, IDLE);
        reset_n = 1'b1;

        // x1 render of 'A'.
        do_write(0, 0, 7'h41, 3'b100);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) drive_pix("x1_a", x, y, 2'b00, 1'b1);

        // x2 and x4 scaling plus range limits.
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 16; x++) drive_pix("x2_a", x, y, 2'b01, 1'b1);
        drive_pix("x2_out", 320, 0, 2'b01, 1'b1);
        drive_pix("x2_edge", 319, 0, 2'b01, 1'b1);
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 32; x++) drive_pix("x4_a", x, y, 2'b10, 1'b1);
        drive_pix("x4_out", 640, 0, 2'b10, 1'b1);
        drive_pix("x4_rowout", 0, 448, 2'b10, 1'b1);
        drive_pix("sel11", 3, 5, 2'b11, 1'b0);
        flush();

        // Out-of-range writes leave the buffer untouched.
        do_write(80, 0, 7'h41, 3'b001);
        do_write(0, 30, 7'h41, 3'b001);
        for (int y = 16; y < 32; y++)
            for (int x = 0; x < 8; x++) drive_pix("oor_wr", x, y, 2'b00, 1'b1);
        flush();

        // Random pixels across the screen at every scale code.
        for (int i = 0; i < 300; i++)
            drive_pix("rand", $urandom_range(0, 799), $urandom_range(0, 524),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        flush();

        // Cursor and blink.
        do_write(5, 3, 7'h41, 3'b010);
        cursor_col = 7'd5;
        cursor_row = 5'd3;
        for (int f = 0; f < 6; f++) begin
`ifdef TEXT_CURSOR_BLINK_EN
            m_inv = ((f / 2) % 2) == 0;
`else
            m_inv = 1'b1;
`endif
            for (int y = 48; y < 64; y++)
                for (int x = 32; x < 56; x++) drive_pix("cursor", x, y, 2'b00, 1'b1);
            flush();
            @(posedge clk); #1;
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
